// File: rtl/cn_msg_gen.sv
// Serial min-sum LDPC check-node update: collects DEG sign-magnitude messages,
// then emits DEG extrinsic check-to-variable messages in edge order.
module cn_msg_gen #(
    parameter int W   = 11,
    parameter int DEG = 5,
    parameter int IW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_msg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_msg,
    output logic [IW-1:0] out_idx,
    output logic          busy
);

    localparam int            MW       = W - 1;
    localparam logic [MW-1:0] MAG_MAX  = '1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEG - 1);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   cnt;
    logic [MW-1:0]   min1;
    logic [MW-1:0]   min2;
    logic [IW-1:0]   idx1;
    logic            sprod;
    logic [DEG-1:0]  sgn;

    logic            accept;
    logic            out_hs;
    logic [MW-1:0]   in_mag;
    logic            in_sgn;
    logic [MW-1:0]   min1_upd;
    logic [MW-1:0]   min2_upd;
    logic [IW-1:0]   idx1_upd;
    logic            sprod_upd;
    logic [DEG-1:0]  sgn_upd;
    logic [IW-1:0]   idx_inc;

    // Extrinsic message for edge k: the smallest magnitude among the other edges,
    // and the sign product with this edge's own sign removed.
    function automatic logic [W-1:0] ext_msg(
        input logic [IW-1:0]  k,
        input logic [MW-1:0]  m1,
        input logic [MW-1:0]  m2,
        input logic [IW-1:0]  i1,
        input logic           sp,
        input logic [DEG-1:0] sg
    );
        logic [MW-1:0] mag;
        mag = (k == i1) ? m2 : m1;
        return {sp ^ sg[k], mag};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_IDX) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && out_idx == LAST_IDX) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign in_mag  = in_msg[MW-1:0];
    assign in_sgn  = in_msg[W-1];
    assign idx_inc = out_idx + 1'b1;

    // Running min1/min2 tracking; strict compares keep the first occurrence in idx1
    always_comb begin
        min1_upd  = min1;
        min2_upd  = min2;
        idx1_upd  = idx1;
        sprod_upd = sprod ^ in_sgn;
        sgn_upd   = sgn;
        sgn_upd[cnt] = in_sgn;
        if (in_mag < min1) begin
            min2_upd = min1;
            min1_upd = in_mag;
            idx1_upd = cnt;
        end else if (in_mag < min2) begin
            min2_upd = in_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            min1    <= MAG_MAX;
            min2    <= MAG_MAX;
            idx1    <= '0;
            sprod   <= 1'b0;
            sgn     <= '0;
            out_msg <= '0;
            out_idx <= '0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                sgn   <= sgn_upd;
                sprod <= sprod_upd;
                min1  <= min1_upd;
                min2  <= min2_upd;
                idx1  <= idx1_upd;
                busy  <= 1'b1;
                if (cnt == LAST_IDX) begin
                    // Edge 0 is formed from the just-updated statistics for 1-cycle latency
                    cnt     <= '0;
                    out_idx <= '0;
                    out_msg <= ext_msg('0, min1_upd, min2_upd, idx1_upd, sprod_upd, sgn_upd);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (out_hs) begin
                if (out_idx == LAST_IDX) begin
                    min1  <= MAG_MAX;
                    min2  <= MAG_MAX;
                    sprod <= 1'b0;
                    idx1  <= '0;
                    busy  <= 1'b0;
                end else begin
                    out_idx <= idx_inc;
                    out_msg <= ext_msg(idx_inc, min1, min2, idx1, sprod, sgn);
                end
            end
        end
    end

endmodule

// File: tb/tb_cn_msg_gen.sv
// Scoreboard bench for cn_msg_gen: driver pushes min-sum expectations per frame,
// monitor compares every presented output against the queue head.
module tb_cn_msg_gen;
    localparam int W   = 11;
    localparam int DEG = 5;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_msg = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_msg;
    logic [IW-1:0] out_idx;
    logic          busy;

    typedef struct {
        logic [W-1:0]  msg;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] frame[$];
    int           errors = 0;
    int           checks = 0;
    int           ready_mode = 0;
    int           rcnt = 0;

    cn_msg_gen #(.W(W), .DEG(DEG), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_msg(out_msg), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each edge gets min magnitude and sign-XOR over all OTHER edges.
    task automatic model_push();
        for (int k = 0; k < DEG; k++) begin
            int   best;
            logic s;
            exp_t e;
            best = 1 << (W - 1);
            s = 1'b0;
            for (int j = 0; j < DEG; j++) begin
                if (j != k) begin
                    logic [W-1:0] f;
                    f = frame[j];
                    if (int'(f[W-2:0]) < best) best = int'(f[W-2:0]);
                    s = s ^ f[W-1];
                end
            end
            e.msg = {s, best[W-2:0]};
            e.idx = IW'(k);
            q.push_back(e);
        end
        frame.delete();
    endtask

    task automatic send_msg(input logic [W-1:0] m);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_msg   = m;
            acc      = in_ready;
            if (acc && frame.size() == 0) begin
                check("prev_frame_drained", 32'(q.size()), 32'd0);
                check("no_out_valid_in_collect", 32'(out_valid), 32'd0);
            end
            @(posedge clk);
            guard++;
            if (!acc && guard > 300) begin
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                $fatal(1, "accept timeout");
            end
        end
        frame.push_back(m);
        if (frame.size() == DEG) begin
            model_push();
            #1;
            check("latency_out_valid", 32'(out_valid), 32'd1);
            check("in_ready_low_emit", 32'(in_ready), 32'd0);
            check("busy_in_frame", 32'(busy), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_msg   = W'($urandom);
        if (n > 1) repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs missing, expected 0", q.size());
            q.delete();
        end
        #1;
        check("busy_after_frame", 32'(busy), 32'd0);
        check("in_ready_after_frame", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        frame.delete();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_msg", 32'(out_msg), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_msg();
        logic [W-2:0] mag;
        case ($urandom_range(0, 3))
            0: mag = (W-1)'($urandom_range(0, 7));
            1: mag = (W-1)'($urandom);
            2: mag = '1;
            default: mag = (W-1)'($urandom_range(0, 31));
        endcase
        return {1'($urandom_range(0, 1)), mag};
    endfunction

    task automatic send_list(input logic [W-1:0] a, b, c, d, e);
        send_msg(a); send_msg(b); send_msg(c); send_msg(d); send_msg(e);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rcnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
    end

    // Monitor: every presented output must match the queue head, stalled or not
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("in_ready_during_emit", 32'(in_ready), 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got msg 0x%0h idx %0d, expected none", out_msg, out_idx);
            end else begin
                check("out_msg", 32'(out_msg), 32'(q[0].msg));
                check("out_idx", 32'(out_idx), 32'(q[0].idx));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        do_reset();

        // Directed frame with mixed signs
        send_list(11'h40C, 11'h004, 11'h009, 11'h406, 11'h014);
        drain();

        // Tied minimum magnitudes
        send_list(11'h003, 11'h007, 11'h003, 11'h009, 11'h005);
        drain();

        // Stalled output with 1,0,0 ready pattern
        ready_mode = 1;
        send_list(11'h40C, 11'h004, 11'h009, 11'h406, 11'h014);
        drain();
        ready_mode = 0;

        // Reset after a partial frame, then a clean frame
        send_msg(rand_msg()); send_msg(rand_msg()); send_msg(rand_msg());
        do_reset();
        send_list(11'h40C, 11'h004, 11'h009, 11'h406, 11'h014);
        drain();

        // Two frames with in_valid held high across the boundary
        ready_mode = 2;
        for (int f = 0; f < 2 * DEG; f++) send_msg(rand_msg());
        drain();

        // Maximum magnitudes, and negative zero pass-through
        ready_mode = 0;
        send_list(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h3FF);
        drain();
        send_list(11'h400, 11'h005, 11'h402, 11'h400, 11'h006);
        drain();

        // Randomized frames with input gaps and random backpressure
        for (int f = 0; f < 40; f++) begin
            ready_mode = $urandom_range(0, 2);
            for (int i = 0; i < DEG; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_msg(rand_msg());
            end
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "global timeout");
    end
endmodule
